// File: rtl/row_config_pkg.sv
// ---------------------------------------------------------------------------
// row_config_pkg
// Shared definitions for the row configuration loader: FSM state encoding,
// default chain/word geometry and a ceil-division helper used to size the
// word counter.
// ---------------------------------------------------------------------------
package row_config_pkg;

    localparam int DEF_CHAIN_LEN = 256;
    localparam int DEF_WORD_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } cfg_state_e;

    // Number of w-bit words needed to carry len bits.
    function automatic int words_for(input int len, input int w);
        return (len + w - 1) / w;
    endfunction

endpackage

// File: rtl/cfg_serializer.sv
// ---------------------------------------------------------------------------
// cfg_serializer
// Word register that turns incoming bitstream words into a one-bit-per-cycle
// stream for the chain head. Counts accepted words so that only the number of
// words the chain needs is taken, and trims the final word to the bits that
// still fit in the chain.
//
// Handshake: a word transfers on a clock edge where valid_i & ready_o are both
// high; valid_i may be raised or dropped at any time and ready_o does not
// depend on valid_i.
//
// Ports:
//   clk_i    in   clock (the chain's prog_clk)
//   rst_i    in   synchronous active-high reset
//   clear_i  in   empty the register and zero the word count
//   run_i    in   loading is active; outputs are inert when low
//   data_i   in   WORD_W bitstream word, bit 0 shifted first
//   valid_i  in   word valid
//   ready_o  out  register can take a word this cycle
//   bit_o    out  bit presented to the chain head (register bit 0)
//   shift_o  out  a bit leaves the register on this edge (chain shift enable)
// ---------------------------------------------------------------------------
module cfg_serializer
    import row_config_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              run_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              bit_o,
    output logic              shift_o
);

    localparam int NUM_WORDS = words_for(CHAIN_LEN, WORD_W);
    // Bits of the last word that still land in the chain (1..WORD_W).
    localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
    localparam int BC_W      = $clog2(WORD_W + 1);
    localparam int WC_W      = $clog2(NUM_WORDS + 1);

    localparam logic [BC_W-1:0] FULL_CNT   = BC_W'(WORD_W);
    localparam logic [BC_W-1:0] LAST_CNT   = BC_W'(LAST_BITS);
    localparam logic [BC_W-1:0] ONE_BIT    = BC_W'(1);
    localparam logic [WC_W-1:0] WORDS_MAX  = WC_W'(NUM_WORDS);
    localparam logic [WC_W-1:0] WORDS_LAST = WC_W'(NUM_WORDS - 1);
    localparam logic [WC_W-1:0] ONE_WORD   = WC_W'(1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [BC_W-1:0]   cnt_q, cnt_d;      // bits still held in word_q
    logic [WC_W-1:0]   words_q, words_d;  // words accepted this load
    logic              accept;

    // Everything below decodes registered state only, so the chain pins never
    // see a combinational path from the configuration bus.
    assign shift_o = run_i && (cnt_q != '0);
    assign bit_o   = word_q[0];
    // Ready while the last held bit is leaving, so a new word lands in the
    // same edge and the chain sees no bubble.
    assign ready_o = run_i && (cnt_q <= ONE_BIT) && (words_q < WORDS_MAX);
    assign accept  = valid_i && ready_o;

    always_comb begin
        word_d  = word_q;
        cnt_d   = cnt_q;
        words_d = words_q;
        if (clear_i) begin
            word_d  = '0;
            cnt_d   = '0;
            words_d = '0;
        end else if (accept) begin
            word_d  = data_i;
            // Surplus high bits of the final word are never shifted out.
            cnt_d   = (words_q == WORDS_LAST) ? LAST_CNT : FULL_CNT;
            words_d = words_q + ONE_WORD;
        end else if (shift_o) begin
            word_d = word_q >> 1;
            cnt_d  = cnt_q - ONE_BIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q  <= '0;
            cnt_q   <= '0;
            words_q <= '0;
        end else begin
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
        end
    end

endmodule

// File: rtl/row_config_loader.sv
// ---------------------------------------------------------------------------
// row_config_loader
// Loads a row's configuration shift chain from a word-wide bitstream, then
// recirculates the chain once (tail back into head) and compares the number
// of ones seen against the number loaded. The recirculation leaves the
// configuration in place.
//
// Handshake: a word transfers on a prog_clk edge where cfg_valid & cfg_ready
// are both high; cfg_ready never depends on cfg_valid.
//
// Ports:
//   prog_clk     in   clock shared with the chain
//   rst          in   synchronous active-high reset
//   cfg_start    in   start pulse, honoured in IDLE/DONE/ERR
//   cfg_abort    in   abort, honoured in LOAD/VERIFY (beats cfg_start there)
//   cfg_data     in   WORD_W bitstream word, LSB first
//   cfg_valid    in   word valid
//   cfg_ready    out  word accepted on cfg_valid & cfg_ready
//   chain_out    in   chain tail
//   prog_in      out  chain head data
//   prog_en      out  chain shift enable
//   busy         out  LOAD or VERIFY
//   done         out  one-cycle pulse after a matching verify
//   error        out  sticky mismatch/abort flag, cleared by a start
//   ones_count   out  ones shifted in during LOAD
//   dbg_state_o  out  current FSM state
// ---------------------------------------------------------------------------
module row_config_loader
    import row_config_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              chain_out,
    output logic              prog_in,
    output logic              prog_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  ones_count,
    output cfg_state_e        dbg_state_o
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;   // bits shifted in the current phase
    logic [CNT_W-1:0] ones_q, ones_d;         // ones loaded
    logic [CNT_W-1:0] vones_q, vones_d;       // ones seen at the tail in VERIFY
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic in_load, in_verify, start_ok;
    logic ser_ready, ser_bit, ser_shift;

    assign in_load   = (state_q == ST_LOAD);
    assign in_verify = (state_q == ST_VERIFY);
    assign start_ok  = cfg_start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});

    cfg_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_serializer (
        .clk_i   (prog_clk),
        .rst_i   (rst),
        .clear_i (start_ok),
        .run_i   (in_load),
        .data_i  (cfg_data),
        .valid_i (cfg_valid),
        .ready_o (ser_ready),
        .bit_o   (ser_bit),
        .shift_o (ser_shift)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        vones_d   = vones_q;
        done_d    = 1'b0;
        error_d   = error_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (cfg_start) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                    ones_d    = '0;
                    vones_d   = '0;
                    error_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                // A bit shifting on the abort edge has reached the chain, so
                // it is still counted.
                if (ser_shift) begin
                    bit_cnt_d = bit_cnt_q + ONE;
                    ones_d    = ones_q + CNT_W'(ser_bit);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_VERIFY;
                        bit_cnt_d = '0;
                    end
                end
                if (cfg_abort) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end
            end
            ST_VERIFY: begin
                bit_cnt_d = bit_cnt_q + ONE;
                vones_d   = vones_q + CNT_W'(chain_out);
                if (bit_cnt_q == LAST_BIT) begin
                    if (vones_d == ones_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
                if (cfg_abort) begin
                    state_d = ST_ERR;
                    done_d  = 1'b0;
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            ones_q    <= '0;
            vones_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ones_q    <= ones_d;
            vones_q   <= vones_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    // In VERIFY the tail feeds straight back into the head so that CHAIN_LEN
    // shifts bring every cell back to its loaded value.
    assign prog_in     = in_verify ? chain_out : (in_load && ser_bit);
    assign prog_en     = in_verify || ser_shift;
    assign cfg_ready   = ser_ready;
    assign busy        = in_load || in_verify;
    assign done        = done_q;
    assign error       = error_q;
    assign ones_count  = ones_q;
    assign dbg_state_o = state_q;

endmodule
